// File: rtl/pixel_pkg.sv
// Shared constants and state encoding for the pixel histogram block.
// Module parameters default to these values so all files agree on geometry.
package pixel_pkg;
  localparam int PIX_W    = 10;
  localparam int BIN_BITS = 6;
  localparam int OUT_W    = 10;
  localparam int OUT_MAX  = 1023;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    ACCUM,
    DUMP
  } histo_state_e;
endpackage

// File: rtl/histo_bin_ram.sv
// NUM_BINS x COUNT_W counter array with a saturating-increment port and a
// read-and-clear port; the two ports are never active in the same cycle.
module histo_bin_ram #(
  parameter int BIN_BITS = pixel_pkg::BIN_BITS,
  parameter int COUNT_W  = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                inc_en,
  input  logic [BIN_BITS-1:0] inc_addr,
  input  logic                clr_en,
  input  logic [BIN_BITS-1:0] rd_addr,
  output logic [COUNT_W-1:0]  rd_data
);
  localparam int NUM_BINS = 2 ** BIN_BITS;
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  logic [COUNT_W-1:0] mem_q [NUM_BINS];
  logic [COUNT_W-1:0] mem_d [NUM_BINS];

  assign rd_data = mem_q[rd_addr];

  always_comb begin
    mem_d = mem_q;
    if (inc_en && (mem_q[inc_addr] != CNT_MAX)) begin
      mem_d[inc_addr] = mem_q[inc_addr] + 1'b1;
    end
    if (clr_en) begin
      mem_d[rd_addr] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/pixel_histogram.sv
// Per-frame intensity histogram of an active-pixel stream; after each frame
// the bins are dumped serially (bin 0 first) and cleared as they are read.
module pixel_histogram #(
  parameter int PIX_W     = pixel_pkg::PIX_W,
  parameter int BIN_BITS  = pixel_pkg::BIN_BITS,
  parameter int COUNT_W   = 24,
  parameter int OUT_SHIFT = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PIX_W-1:0]    pixel_in,
  input  logic                line_valid,
  input  logic                frame_valid,
  output logic [9:0]          histo_data,
  output logic                histo_valid,
  output logic [BIN_BITS-1:0] histo_bin,
  output logic                histo_last,
  output logic                busy
);
  import pixel_pkg::*;

  localparam logic [BIN_BITS-1:0] LAST_BIN = '1;

  function automatic logic [9:0] sat_out(input logic [COUNT_W-1:0] cnt);
    logic [COUNT_W-1:0] shifted;
    shifted = cnt >> OUT_SHIFT;
    if (shifted > COUNT_W'(OUT_MAX)) begin
      return 10'(OUT_MAX);
    end
    return shifted[9:0];
  endfunction

  histo_state_e          state_q, state_d;
  logic                  fv_dly_q, fv_dly_d;
  logic [BIN_BITS-1:0]   idx_q, idx_d;
  logic [9:0]            histo_data_q, histo_data_d;
  logic                  histo_valid_q, histo_valid_d;
  logic [BIN_BITS-1:0]   histo_bin_q, histo_bin_d;
  logic                  histo_last_q, histo_last_d;
  logic                  busy_q, busy_d;

  logic                  rise;
  logic                  fall;
  logic                  inc_en;
  logic                  emit;
  logic [BIN_BITS-1:0]   rd_addr;
  logic [COUNT_W-1:0]    rd_count;

  assign rise = frame_valid & ~fv_dly_q;
  assign fall = ~frame_valid & fv_dly_q;

  histo_bin_ram #(
    .BIN_BITS (BIN_BITS),
    .COUNT_W  (COUNT_W)
  ) u_bins (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc_en   (inc_en),
    .inc_addr (pixel_in[PIX_W-1 -: BIN_BITS]),
    .clr_en   (emit),
    .rd_addr  (rd_addr),
    .rd_data  (rd_count)
  );

  // Bin 0 is emitted in the fall cycle itself so the first word lands one
  // cycle after the fall; idx_q then always names the next bin to emit.
  always_comb begin
    state_d       = state_q;
    fv_dly_d      = frame_valid;
    idx_d         = idx_q;
    histo_data_d  = histo_data_q;
    histo_bin_d   = histo_bin_q;
    histo_valid_d = 1'b0;
    histo_last_d  = 1'b0;
    busy_d        = 1'b0;
    inc_en        = 1'b0;
    emit          = 1'b0;
    rd_addr       = idx_q;

    case (state_q)
      SYNC: begin
        if (!frame_valid) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (rise) begin
          state_d = ACCUM;
          inc_en  = line_valid;
        end
      end
      ACCUM: begin
        inc_en = frame_valid & line_valid;
        if (fall) begin
          emit    = 1'b1;
          rd_addr = '0;
          idx_d   = BIN_BITS'(1);
          state_d = DUMP;
        end
      end
      DUMP: begin
        emit  = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_BIN) begin
          state_d = SYNC;
        end
      end
      default: state_d = SYNC;
    endcase

    if (emit) begin
      histo_data_d  = sat_out(rd_count);
      histo_bin_d   = rd_addr;
      histo_valid_d = 1'b1;
      histo_last_d  = (rd_addr == LAST_BIN);
      busy_d        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= SYNC;
      fv_dly_q      <= 1'b0;
      idx_q         <= '0;
      histo_data_q  <= '0;
      histo_valid_q <= 1'b0;
      histo_bin_q   <= '0;
      histo_last_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fv_dly_q      <= fv_dly_d;
      idx_q         <= idx_d;
      histo_data_q  <= histo_data_d;
      histo_valid_q <= histo_valid_d;
      histo_bin_q   <= histo_bin_d;
      histo_last_q  <= histo_last_d;
      busy_q        <= busy_d;
    end
  end

  assign histo_data  = histo_data_q;
  assign histo_valid = histo_valid_q;
  assign histo_bin   = histo_bin_q;
  assign histo_last  = histo_last_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_pixel_histogram.sv
// Bench for pixel_histogram: two instances (24-bit counters/no shift and
// 11-bit counters/shift 1) share one stimulus and a per-frame bin model.
module tb_pixel_histogram;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] pixel_in;
  logic       line_valid;
  logic       frame_valid;

  logic [9:0] h_data  [2];
  logic       h_valid [2];
  logic [5:0] h_bin   [2];
  logic       h_last  [2];
  logic       h_busy  [2];

  int checks = 0;
  int errors = 0;

  int unsigned m_cnt [2][64];
  int unsigned shf   [2] = '{0, 1};
  int unsigned cmax  [2] = '{32'h00FF_FFFF, 32'd2047};
  bit          counting;

  always #5 clk = ~clk;

  pixel_histogram #(.COUNT_W(24), .OUT_SHIFT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .pixel_in(pixel_in),
    .line_valid(line_valid), .frame_valid(frame_valid),
    .histo_data(h_data[0]), .histo_valid(h_valid[0]), .histo_bin(h_bin[0]),
    .histo_last(h_last[0]), .busy(h_busy[0])
  );

  pixel_histogram #(.COUNT_W(11), .OUT_SHIFT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .pixel_in(pixel_in),
    .line_valid(line_valid), .frame_valid(frame_valid),
    .histo_data(h_data[1]), .histo_valid(h_valid[1]), .histo_bin(h_bin[1]),
    .histo_last(h_last[1]), .busy(h_busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 64; b++) m_cnt[i][b] = 0;
  endtask

  task automatic model_add(input int b);
    for (int i = 0; i < 2; i++)
      if (m_cnt[i][b] < cmax[i]) m_cnt[i][b]++;
  endtask

  function automatic int unsigned exp_out(input int i, input int b);
    int unsigned s;
    s = m_cnt[i][b] >> shf[i];
    return (s > 1023) ? 1023 : s;
  endfunction

  task automatic pix(input logic [9:0] v, input logic lv);
    pixel_in    = v;
    line_valid  = lv;
    frame_valid = 1'b1;
    if (lv && counting) model_add(int'(v[9:4]));
    tick();
  endtask

  task automatic idle(input int n);
    frame_valid = 1'b0;
    line_valid  = 1'b0;
    pixel_in    = 10'h200;
    repeat (n) tick();
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_data%0d", tag, i),  h_data[i],  0);
      chk($sformatf("%s_valid%0d", tag, i), h_valid[i], 0);
      chk($sformatf("%s_bin%0d", tag, i),   h_bin[i],   0);
      chk($sformatf("%s_last%0d", tag, i),  h_last[i],  0);
      chk($sformatf("%s_busy%0d", tag, i),  h_busy[i],  0);
    end
  endtask

  // Drop frame_valid (line_valid left as is) and expect 64 back-to-back words.
  task automatic dump_check(input string tag, input bit intrude);
    frame_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_pre_valid%0d", tag, i), h_valid[i], 0);
      chk($sformatf("%s_pre_busy%0d", tag, i),  h_busy[i],  0);
    end
    for (int k = 0; k < 64; k++) begin
      tick();
      if (k == 0) line_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("%s_valid%0d_w%0d", tag, i, k), h_valid[i], 1);
        chk($sformatf("%s_busy%0d_w%0d", tag, i, k),  h_busy[i],  1);
        chk($sformatf("%s_bin%0d_w%0d", tag, i, k),   h_bin[i],   k);
        chk($sformatf("%s_data%0d_w%0d", tag, i, k),  h_data[i],  exp_out(i, k));
        chk($sformatf("%s_last%0d_w%0d", tag, i, k),  h_last[i],  (k == 63) ? 1 : 0);
      end
      if (intrude && k == 9) begin
        frame_valid = 1'b1;
        line_valid  = 1'b1;
        pixel_in    = 10'($urandom);
      end
    end
    model_clear();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_post_valid%0d", tag, i), h_valid[i], 0);
      chk($sformatf("%s_post_busy%0d", tag, i),  h_busy[i],  0);
      chk($sformatf("%s_post_last%0d", tag, i),  h_last[i],  0);
    end
  endtask

  // Watch n cycles and require that no word is produced.
  task automatic quiet_check(input string tag, input int n);
    int seen [2];
    seen = '{0, 0};
    repeat (n) begin
      tick();
      for (int i = 0; i < 2; i++) if (h_valid[i] || h_busy[i]) seen[i]++;
    end
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s_words%0d", tag, i), seen[i], 0);
  endtask

  initial begin
    reset_n     = 1'b0;
    frame_valid = 1'b0;
    line_valid  = 1'b0;
    pixel_in    = '0;
    counting    = 1'b1;
    model_clear();
    repeat (3) tick();
    chk_reset("reset");
    reset_n = 1'b1;
    idle(2);

    // 4 lines x 8 pixels of zero
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 8; p++) pix(10'h000, 1'b1);
      if (l != 3) repeat (3) pix(10'h200, 1'b0);
    end
    dump_check("zeros", 1'b0);
    idle(2);

    // ramp twice: clear-on-read must leave every bin at exactly one
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 64; p++) pix(10'(p * 16), 1'b1);
      dump_check($sformatf("ramp%0d", f), 1'b0);
      idle(2);
    end

    // 2000 then 2100 pixels in bin 5: output clamp and counter saturation
    for (int p = 0; p < 2000; p++) pix(10'h050, 1'b1);
    dump_check("sat2000", 1'b0);
    idle(2);
    for (int p = 0; p < 2100; p++) pix(10'h050, 1'b1);
    dump_check("sat2100", 1'b0);
    idle(2);

    // pixels outside line_valid are 0x200 and must not land in bin 32
    for (int p = 0; p < 5; p++) begin
      pix(10'h200, 1'b0);
      pix(10'h100, 1'b1);
    end
    pix(10'h200, 1'b0);
    dump_check("gated", 1'b0);
    idle(2);

    // random frame whose dump is interrupted by a new frame at dump cycle 10
    for (int l = 0; l < 6; l++) begin
      int n;
      n = int'($urandom_range(5, 40));
      for (int p = 0; p < n; p++) pix(10'($urandom), ($urandom_range(0, 3) != 0));
      repeat (2) pix(10'($urandom), 1'b0);
    end
    pix(10'($urandom), 1'b1);
    dump_check("rand_a", 1'b1);
    counting = 1'b0;
    for (int p = 0; p < 20; p++) pix(10'($urandom), 1'b1);
    counting = 1'b1;
    idle(1);
    quiet_check("dropped", 80);

    // following random frame, fall with line_valid still high
    for (int p = 0; p < 150; p++) pix(10'($urandom), ($urandom_range(0, 4) != 0));
    pixel_in   = 10'h3C0;
    line_valid = 1'b1;
    dump_check("rand_b", 1'b0);
    idle(2);

    // reset for one cycle mid-frame; the rest of that frame is ignored
    for (int p = 0; p < 10; p++) pix(10'($urandom), 1'b1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_clear();
    chk_reset("midreset");
    counting = 1'b0;
    for (int p = 0; p < 10; p++) pix(10'($urandom), 1'b1);
    counting = 1'b1;
    idle(1);
    quiet_check("after_reset", 80);
    idle(2);
    for (int p = 0; p < 8; p++) pix(10'h3FF, 1'b1);
    dump_check("top_bin", 1'b0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
